// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   DATA_BITS / STOP_BITS   8N1 frame shape (no parity)
//   ST_* / rx_state_t       receiver FSM encodings (3 bits)
//   calc_clks_per_bit()     clocks per bit from clock and baud rate
//   calc_half_bit()         offset from start edge to first sample point
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE      = ST_IDLE,
    RX_START     = ST_START,
    RX_DATA      = ST_DATA,
    RX_STOP      = ST_STOP,
    RX_WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_t;

  // Integer division: the residual baud error is absorbed by sampling mid-bit.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int calc_half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2 -- two-flop synchronizer for a single asynchronous input.
//
// Parameters:
//   INIT   value both flops take during reset (1 suits an idle-high line)
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   d      asynchronous input
//   q      synchronized output, two clocks behind d
// ---------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_p0;

  // Stage 0: first flop may go metastable; stage 1 gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= INIT;
      q       <= INIT;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with held-valid/ack output.
//
// Parameters:
//   CLK_FREQ    clock frequency in Hz (default 12 MHz)
//   BAUD_RATE   line bit rate (default 115200 -> 104 clocks per bit)
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx_line     asynchronous serial line, idle high
//   rx_data     last correctly framed byte
//   rx_valid    high while rx_data holds an unacknowledged byte
//   rx_ack      one-cycle strobe from the consumer; clears rx_valid
//   rx_error    one-cycle pulse: stop bit sampled low
//   rx_overrun  one-cycle pulse: byte completed while rx_valid was high
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit is the 2-of-3 majority of
//                        the samples at target-1, target and target+1, which
//                        rejects single-cycle glitches; delivery moves one
//                        clock later. Undefined: one sample at the target.
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_error,
  output logic       rx_overrun
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLKS_PER_BIT);

  if (CLKS_PER_BIT < 8) begin : g_rate_check
    $error("uart_rx: CLKS_PER_BIT must be at least 8");
  end
  if (STOP_BITS != 1) begin : g_frame_check
    $error("uart_rx: only one stop bit is supported");
  end

`ifdef UART_RX_MAJORITY_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  // The counter must reach CLKS_PER_BIT when the decision moves to target+1.
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_TGT    = CNT_W'(HALF_BIT - 1 + OFS);
  localparam logic [CNT_W-1:0] FULL_TGT    = CNT_W'(CLKS_PER_BIT - 1 + OFS);
  // Restarting at OFS keeps the spacing between decisions at CLKS_PER_BIT.
  localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(OFS);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  logic                 rx_s;
  logic                 sample_bit;
  rx_state_t            state,    state_nxt;
  logic [CNT_W-1:0]     cnt,      cnt_nxt;
  logic [IDX_W-1:0]     idx,      idx_nxt;
  logic                 shift_en;
  logic                 frame_ok;
  logic                 frame_bad;
  logic [DATA_BITS-1:0] shift_p1;
  logic                 done_p1;

  // Stage 0: bring the asynchronous line into the clock domain.
  uart_sync2 #(
    .INIT (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_line),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_p0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // hist_p0[1] / hist_p0[0] hold rx_s from two and one cycles earlier, so at
  // target+1 they are the target-1 and target samples.
  always_ff @(posedge clk) begin
    hist_p0 <= {hist_p0[0], rx_s};
  end

  assign sample_bit = maj3(hist_p0[1], hist_p0[0], rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // Stage 1: frame FSM, bit counter and bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RX_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    idx_nxt   = idx;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (cnt == HALF_TGT) begin
          if (!sample_bit) begin
            state_nxt = RX_DATA;
            cnt_nxt   = CNT_RESTART;
            idx_nxt   = '0;
          end else begin
            // Line was high again at mid start bit: a glitch, not a frame.
            state_nxt = RX_IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      RX_DATA: begin
        if (cnt == FULL_TGT) begin
          shift_en = 1'b1;
          cnt_nxt  = CNT_RESTART;
          idx_nxt  = idx + IDX_ONE;
          if (idx == LAST_IDX) begin
            state_nxt = RX_STOP;
            idx_nxt   = '0;
          end
        end
      end
      RX_STOP: begin
        if (cnt == FULL_TGT) begin
          cnt_nxt = '0;
          // Leaving at the stop mid-point leaves half a bit to catch the
          // next start edge of a back-to-back frame.
          if (sample_bit) begin
            frame_ok  = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A break holds the line low; only one error is raised for it.
        cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = RX_IDLE;
        end
      end
      default: begin
        state_nxt = RX_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Stage 1: right shift so the first (LSB) bit ends at bit 0.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shift_p1 <= {sample_bit, shift_p1[DATA_BITS-1:1]};
    end
  end

  // Stage 2: delivery one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_p1    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      done_p1    <= frame_ok;
      rx_error   <= frame_bad;
      rx_overrun <= 1'b0;
      if (done_p1) begin
        // An ack in the delivery cycle frees the holding register in time.
        if (!rx_valid || rx_ack) begin
          rx_data  <= shift_p1;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx at 12 MHz / 115200 baud.
// Stimulus pushes expected events (byte delivery, framing error, overrun)
// into a queue; a monitor pops and compares whenever the DUT shows one.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 12000000 / 115200;  // 104
  localparam int LAT = 992;                // start edge to rx_valid, nominal
  localparam int TOL = 3;
`ifdef UART_RX_MAJORITY_EN
  localparam int DELIV_EDGE = 993;
`else
  localparam int DELIV_EDGE = 992;
`endif

  localparam int K_DATA = 0;
  localparam int K_ERR  = 1;
  localparam int K_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] b;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_error;
  logic       rx_overrun;

  exp_t       q[$];
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         auto_ack = 1'b0;
  bit         manual_ack = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .rx_line    (rx_line),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_error   (rx_error),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: single driver of rx_ack, updated 2 time units after each edge.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rx_ack = manual_ack || (auto_ack && (rx_valid === 1'b1) && !rx_ack);
    end
  end

  function automatic string kname(input int k);
    return (k == K_DATA) ? "data" : (k == K_ERR) ? "error" : "overrun";
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] b);
    exp_t e;
    e.kind  = kind;
    e.b     = b;
    e.start = cyc;
    q.push_back(e);
  endtask

  task automatic check_event(input int kind, input bit rose);
    exp_t e;
    int   lat;
    n_run++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got data=%02h at cycle %0d, want no event", kname(kind), rx_data, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.b !== rx_data) begin
      n_fail++;
      $display("FAIL event_%s: got %s data=%02h, want %s data=%02h",
               kname(e.kind), kname(kind), rx_data, kname(e.kind), e.b);
    end
    if (kind == K_DATA && e.kind == K_DATA && rose) begin
      lat = cyc - e.start;
      n_run++;
      if (lat < LAT - TOL || lat > LAT + TOL) begin
        n_fail++;
        $display("FAIL latency_%02h: got %0d clocks, want %0d +/- %0d", e.b, lat, LAT, TOL);
      end
    end
  endtask

  // Monitor: a delivery is rx_valid rising, or new data while rx_valid stays high.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 && (prev_valid !== 1'b1 || rx_data !== prev_data))
      check_event(K_DATA, prev_valid !== 1'b1);
    if (rx_error === 1'b1)   check_event(K_ERR, 1'b0);
    if (rx_overrun === 1'b1) check_event(K_OVR, 1'b0);
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  // Called at posedge+1; returns at posedge+1 at the end of the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int glitch_bit);
    rx_line = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      if (i == glitch_bit) begin
        repeat (CPB / 2) @(posedge clk);
        #1 rx_line = 1'b1;
        @(posedge clk);
        #1 rx_line = b[i];
        repeat (CPB - CPB / 2 - 1) @(posedge clk);
        #1;
      end else begin
        repeat (CPB) @(posedge clk);
        #1;
      end
    end
    rx_line = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    manual_ack = 1'b1;
    @(posedge clk);
    #1 manual_ack = 1'b0;
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check8("reset_rx_data", rx_data, 8'h00);
    check8("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    check8("reset_rx_error", {7'd0, rx_error}, 8'h00);
    check8("reset_rx_overrun", {7'd0, rx_overrun}, 8'h00);

    // Ack with nothing held is ignored.
    pulse_ack();
    idle(2);
    check8("ack_when_empty", {7'd0, rx_valid}, 8'h00);

    // Single frame, acked one cycle after valid.
    auto_ack = 1'b1;
    expect_ev(K_DATA, 8'h2E);
    send_frame(8'h2E, 1'b1, -1);
    idle(20);
    check8("valid_cleared_by_ack", {7'd0, rx_valid}, 8'h00);

    // Back-to-back frames, no idle gap.
    expect_ev(K_DATA, 8'h00);
    send_frame(8'h00, 1'b1, -1);
    expect_ev(K_DATA, 8'hFF);
    send_frame(8'hFF, 1'b1, -1);
    idle(20);

    // Short low pulse is a false start; a real frame follows.
    rx_line = 1'b0;
    idle(20);
    rx_line = 1'b1;
    idle(200);
    check8("false_start_no_valid", {7'd0, rx_valid}, 8'h00);
    expect_ev(K_DATA, 8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    idle(20);

    // Bad stop bit followed by a long break: one error, old byte kept.
    expect_ev(K_ERR, 8'hA5);
    send_frame(8'h55, 1'b0, -1);
    idle(3000);
    rx_line = 1'b1;
    idle(50);
    check8("break_no_valid", {7'd0, rx_valid}, 8'h00);
    expect_ev(K_DATA, 8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    idle(20);

    // Overrun: second byte arrives while first is unacknowledged.
    auto_ack = 1'b0;
    expect_ev(K_DATA, 8'h11);
    send_frame(8'h11, 1'b1, -1);
    expect_ev(K_OVR, 8'h11);
    send_frame(8'h22, 1'b1, -1);
    idle(20);
    check8("overrun_keeps_data", rx_data, 8'h11);
    check8("overrun_keeps_valid", {7'd0, rx_valid}, 8'h01);
    pulse_ack();
    idle(5);

    // Ack in the delivery cycle of the second byte: no overrun.
    expect_ev(K_DATA, 8'h11);
    send_frame(8'h11, 1'b1, -1);
    expect_ev(K_DATA, 8'h22);
    fork
      send_frame(8'h22, 1'b1, -1);
      begin
        repeat (DELIV_EDGE - 1) @(posedge clk);
        #1 manual_ack = 1'b1;
        @(posedge clk);
        #1 manual_ack = 1'b0;
      end
    join
    idle(20);
    check8("ack_in_delivery_data", rx_data, 8'h22);
    pulse_ack();
    idle(5);

    // Reset during data bit 4 of a frame whose remaining bits are all high.
    expect_ev(K_DATA, 8'h99);
    send_frame(8'h99, 1'b1, -1);
    fork
      send_frame(8'hF0, 1'b1, -1);
      begin
        repeat (5 * CPB + CPB / 2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check8("midframe_reset_data", rx_data, 8'h00);
        check8("midframe_reset_valid", {7'd0, rx_valid}, 8'h00);
        check8("midframe_reset_error", {7'd0, rx_error}, 8'h00);
        check8("midframe_reset_overrun", {7'd0, rx_overrun}, 8'h00);
      end
    join
    idle(50);
    check8("aborted_frame_not_delivered", {7'd0, rx_valid}, 8'h00);
    auto_ack = 1'b1;
    expect_ev(K_DATA, 8'h7E);
    send_frame(8'h7E, 1'b1, -1);
    idle(20);

`ifdef UART_RX_MAJORITY_EN
    // One-clock high glitch at the mid-point of data bit 3 is outvoted.
    expect_ev(K_DATA, 8'h00);
    send_frame(8'h00, 1'b1, 3);
    idle(20);
`endif

    idle(50);
    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART: the stage downstream of the transmit line driven by the UART transmitter.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) from an asynchronous serial line.
- Presents each byte on a held-valid/ack interface, with framing-error and overrun flags.
- Targets the 12 MHz board clock at 115200 baud, matching the transmitter's defaults.

Parameters:
CLK_FREQ, 12000000, clock frequency in Hz
BAUD_RATE, 115200, line bit rate
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, 104 at defaults), clocks per bit; elaboration error if < 8
HALF_BIT, CLKS_PER_BIT/2 (52 at defaults), offset from detected start edge to first sample point

Ports:
clk  input  1  system clock (12 MHz)
reset  input  1  synchronous, active-high reset
rx_line  input  1  asynchronous serial line, idle high
rx_data  output  8  last correctly framed byte
rx_valid  output  1  high while rx_data holds an unacknowledged byte
rx_ack  input  1  one-cycle strobe from consumer; clears rx_valid
rx_error  output  1  one-cycle pulse: stop bit sampled low
rx_overrun  output  1  one-cycle pulse: byte completed while rx_valid high

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values:
  - rx_data = 0x00; rx_valid, rx_error, rx_overrun = 0.
  - Synchronizer flops = 1; FSM = IDLE; all counters = 0.
  - Reset mid-frame abandons the frame; no flags are raised.
- Input sync: rx_line passes through 2 flops to give rx_s. Only rx_s is used internally.
- FSM: IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter (0..CLKS_PER_BIT-1) and a bit index (0..7) run alongside it.
- IDLE: when rx_s = 0, go to START and clear the counter.
- START: at counter = HALF_BIT-1, sample.
  - If low, go to DATA with counter and index cleared.
  - If high, treat it as a glitch: return to IDLE silently.
- DATA: at counter = CLKS_PER_BIT-1, sample and shift into the shift register MSB (right-shift, so the byte ends LSB-first).
  - Increment the index and clear the counter.
  - After index 7, go to STOP.
- STOP: at counter = CLKS_PER_BIT-1, sample.
  - High: deliver the byte, go to IDLE.
  - Low: pulse rx_error, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. A break condition therefore yields exactly one rx_error.
- Delivery, in the cycle after the stop sample:
  - If rx_valid = 0, or rx_ack is high in the same cycle: load rx_data and set rx_valid = 1. No overrun.
  - Otherwise: keep the old rx_data, pulse rx_overrun, leave rx_valid = 1.
- rx_ack with rx_valid = 0 is ignored.
- rx_valid rises about 2 + HALF_BIT + 9*CLKS_PER_BIT + 2 clocks after the rx_line falling edge (≈992 at defaults). The bench checks within ±3 clocks.
- Back-to-back frames: IDLE is re-entered at the stop mid-point, so a start bit directly after the stop bit is caught.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample point takes rx_s at counter target-1, target and target+1.
  - The bit value is the 2-of-3 majority, decided at target+1.
  - Counters then continue from 1 so bit spacing stays CLKS_PER_BIT.
  - A single-cycle glitch at a mid-bit point is rejected.
  - Delivery is 1 clock later.
- Undefined: single sample at the target count, exactly as described above.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings (3-bit localparams).
  - The CLKS_PER_BIT/HALF_BIT computation.
  - The frame constants DATA_BITS = 8 and STOP_BITS = 1, also used by the transmitter.
- One sub-module: uart_sync2, a 2-flop synchronizer with reset value parameter INIT = 1. It is reusable for other asynchronous inputs.

Test Plan:
- Frame 0x2E at 115200 baud (104 clocks/bit), ack one cycle after valid -> rx_data = 0x2E, rx_valid high then cleared by ack, rx_error = rx_overrun = 0.
- Frames 0x00 then 0xFF back-to-back (no idle gap), ack each -> two deliveries 0x00, 0xFF in order, no flags.
- rx_line low for 20 clocks, then high -> no rx_valid, no rx_error, FSM back to IDLE. A following 0xA5 frame is received correctly.
- 0x55 frame with stop bit low, then line held low 3000 clocks, then high, then frame 0x3C -> exactly one rx_error pulse, rx_valid stays 0, then 0x3C delivered.
- Frames 0x11 and 0x22 with no ack -> rx_data stays 0x11, one rx_overrun pulse at the second delivery. Same pair with rx_ack asserted in the second byte's delivery cycle -> rx_data = 0x22, no overrun.
- reset asserted for 1 clock during data bit 4 of a frame -> all outputs 0 next cycle. Next full frame 0x7E is received. With UART_RX_MAJORITY_EN, a 1-clock high glitch at the mid-point of a 0 data bit in 0x00 still yields 0x00.
